// File: rtl/pc_sequencer.sv
// Program-counter sequencer: chooses the next fetch address from step, branch, jump,
// call or return, with a circular return-address stack that drops its oldest entry when full.
module pc_sequencer #(
   parameter int unsigned          ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]    RESET_VECTOR = ADDR_W'(32'h0100_0000),
   parameter int unsigned          STEP         = 4,
   parameter int unsigned          OFF_W        = 16,
   parameter int unsigned          RAS_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [2:0]        cmd,
   input  logic [ADDR_W-1:0] target,
   input  logic [OFF_W-1:0]  offset,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_updated,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_overflow,
   output logic              ras_underflow
);

   localparam int unsigned       PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned       CNT_W      = $clog2(RAS_DEPTH + 1);
   localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP_V - ADDR_W'(1));
   localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RAS_DEPTH);

   typedef enum logic {ST_BOOT, ST_RUN} state_e;

   typedef enum logic [2:0] {
      CMD_SEQ    = 3'd0,
      CMD_BRANCH = 3'd1,
      CMD_JUMP   = 3'd2,
      CMD_CALL   = 3'd3,
      CMD_RET    = 3'd4
   } cmd_e;

   state_e                    state_q;
   logic [ADDR_W-1:0]         pc_q, pc_d;
   logic                      upd_q, ovf_q, unf_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [PTR_W-1:0]          ptr_q;
   logic [ADDR_W-1:0]         ras_q [RAS_DEPTH];

   logic signed [ADDR_W-1:0]  off_ext;
   logic [ADDR_W-1:0]         step_pc, raw_pc;
   logic [PTR_W-1:0]          top_idx, next_ptr;
   logic                      do_push, do_pop, underflow;
   logic                      run_en;

   assign off_ext = $signed(offset);
   assign run_en  = (state_q == ST_RUN) && enable;

   // ptr_q is the next free slot; the top of stack sits one below it, circularly.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      step_pc   = pc_q + STEP_V;
      top_idx   = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);
      next_ptr  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      raw_pc    = step_pc;
      do_push   = 1'b0;
      do_pop    = 1'b0;
      underflow = 1'b0;
      case (cmd)
         CMD_BRANCH: raw_pc = pc_q + off_ext;
         CMD_JUMP:   raw_pc = target;
         CMD_CALL: begin
            raw_pc  = target;
            do_push = 1'b1;
         end
         CMD_RET: begin
            if (cnt_q != '0) begin
               raw_pc = ras_q[top_idx];
               do_pop = 1'b1;
            end else begin
               raw_pc    = target;
               underflow = 1'b1;
            end
         end
         default: raw_pc = step_pc;
      endcase
      pc_d = raw_pc & ALIGN_MASK;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VECTOR;
         upd_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         upd_q <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         case (state_q)
            ST_BOOT: begin
               state_q <= ST_RUN;
               upd_q   <= 1'b1;
            end
            ST_RUN: begin
               if (enable) begin
                  pc_q  <= pc_d;
                  upd_q <= 1'b1;
                  unf_q <= underflow;
                  if (do_push) begin
                     ptr_q <= next_ptr;
                     if (cnt_q == CNT_FULL) ovf_q <= 1'b1;
                     else                   cnt_q <= cnt_q + CNT_W'(1);
                  end else if (do_pop) begin
                     ptr_q <= top_idx;
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            default: state_q <= ST_BOOT;
         endcase
      end
   end

   // NOTE: stack storage has no reset; an entry is only read after a push has written it.
   always_ff @(posedge clk) begin
      if (run_en && do_push) ras_q[ptr_q] <= step_pc;
   end

   assign pc            = pc_q;
   assign pc_updated    = upd_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
   assign ras_empty     = (cnt_q == '0);
   assign ras_full      = (cnt_q == CNT_FULL);

endmodule
